// File: rtl/hazard_scoreboard_if.sv
// Decode-field handshake between the ID stage and the hazard scoreboard.
// Master drives per-instruction fields; slave returns stall and forwarding selects.
interface hazard_scoreboard_if #(
    parameter int STALL_CNT_W = 32
);
    logic                   id_valid;
    logic [4:0]             id_rs_addr;
    logic [4:0]             id_rt_addr;
    logic [4:0]             id_write_reg_addr;
    logic                   id_reg_write;
    logic                   id_is_mem_access;
    logic                   id_is_branch;
    logic                   id_is_mdu;
    logic                   stall;
    logic [1:0]             ex_fwd_rs_sel;
    logic [1:0]             ex_fwd_rt_sel;
    logic [1:0]             id_br_fwd_rs_sel;
    logic [1:0]             id_br_fwd_rt_sel;
    logic                   mdu_busy;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_write_reg_addr,
        output id_reg_write, id_is_mem_access, id_is_branch, id_is_mdu,
        input  stall, ex_fwd_rs_sel, ex_fwd_rt_sel,
        input  id_br_fwd_rs_sel, id_br_fwd_rt_sel, mdu_busy, stall_count
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_write_reg_addr,
        input  id_reg_write, id_is_mem_access, id_is_branch, id_is_mdu,
        output stall, ex_fwd_rs_sel, ex_fwd_rt_sel,
        output id_br_fwd_rs_sel, id_br_fwd_rt_sel, mdu_busy, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight GPR writers in EX/MEM/WB and the MDU busy window;
// produces the ID stall plus EX and ID-branch forwarding selects.
module hazard_scoreboard #(
    parameter int MDU_CYCLES  = 8,
    parameter int STALL_CNT_W = 32
) (
    input logic clk,
    input logic reset,
    hazard_scoreboard_if.slave hz
);
    localparam int CW = $clog2(MDU_CYCLES + 1);

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       is_load;
    } slot_t;

    slot_t ex_q, mem_q, wb_q, id_slot;

    logic [CW-1:0]          mdu_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [1:0]             ex_rs_q, ex_rt_q;
    logic [1:0]             ex_rs_d, ex_rt_d;
    logic                   stall, advance, mdu_wr, mdu_busy;
    logic                   ex_hit, mem_hit;
    logic [4:0]             rs, rt;

    function automatic logic hit(slot_t s, logic [4:0] r);
        return s.valid && (r != 5'd0) && (r == s.dst);
    endfunction

    // Newer producer wins: EX/MEM result beats MEM/WB result.
    function automatic logic [1:0] ex_sel(slot_t e, slot_t m,
                                          logic [4:0] r);
        logic [1:0] s;
        s = 2'd0;
        priority case (1'b1)
            hit(e, r): s = 2'd1;
            hit(m, r): s = 2'd2;
            default:   s = 2'd0;
        endcase
        return s;
    endfunction

    // A load in MEM has no data yet, so it never feeds a branch.
    function automatic logic [1:0] br_sel(slot_t m, slot_t w,
                                          logic [4:0] r);
        logic [1:0] s;
        s = 2'd0;
        priority case (1'b1)
            hit(m, r) && !m.is_load: s = 2'd1;
            hit(w, r):               s = 2'd2;
            default:                 s = 2'd0;
        endcase
        return s;
    endfunction

    always_comb begin
        rs = hz.id_rs_addr;
        rt = hz.id_rt_addr;
        id_slot.valid   = hz.id_reg_write
                       && (hz.id_write_reg_addr != 5'd0);
        id_slot.dst     = hz.id_write_reg_addr;
        id_slot.is_load = hz.id_is_mem_access && hz.id_reg_write;
        mdu_wr   = hz.id_is_mdu && !hz.id_reg_write;
        mdu_busy = (mdu_cnt_q != '0);
        ex_hit   = hit(ex_q, rs) || hit(ex_q, rt);
        mem_hit  = hit(mem_q, rs) || hit(mem_q, rt);
        stall = hz.id_valid && (
                    (ex_hit && ex_q.is_load)
                 || (hz.id_is_branch && ex_hit)
                 || (hz.id_is_branch && mem_hit && mem_q.is_load)
                 || (hz.id_is_mdu && mdu_busy));
        advance = hz.id_valid && !stall;
        ex_rs_d = ex_sel(ex_q, mem_q, rs);
        ex_rt_d = ex_sel(ex_q, mem_q, rt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            ex_rs_q     <= 2'd0;
            ex_rt_q     <= 2'd0;
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (advance) begin
                ex_q    <= id_slot;
                ex_rs_q <= ex_rs_d;
                ex_rt_q <= ex_rt_d;
            end else begin
                ex_q    <= '0;
                ex_rs_q <= 2'd0;
                ex_rt_q <= 2'd0;
            end
            if (advance && mdu_wr)
                mdu_cnt_q <= CW'(MDU_CYCLES);
            else if (mdu_busy)
                mdu_cnt_q <= mdu_cnt_q - CW'(1);
            if (stall)
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign hz.stall            = stall;
    assign hz.ex_fwd_rs_sel    = ex_rs_q;
    assign hz.ex_fwd_rt_sel    = ex_rt_q;
    assign hz.id_br_fwd_rs_sel = br_sel(mem_q, wb_q, rs);
    assign hz.id_br_fwd_rt_sel = br_sel(mem_q, wb_q, rt);
    assign hz.mdu_busy         = mdu_busy;
    assign hz.stall_count      = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, forwarding,
// branch hazards, MDU busy window, $0 writers and async reset.
module tb_hazard_scoreboard;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   cnt;

    hazard_scoreboard_if #(.STALL_CNT_W(32)) hz ();

    hazard_scoreboard #(.MDU_CYCLES(8), .STALL_CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] wd,
                         input logic rw, input logic mem,
                         input logic br, input logic mdu);
        hz.id_valid          = v;
        hz.id_rs_addr        = rs;
        hz.id_rt_addr        = rt;
        hz.id_write_reg_addr = wd;
        hz.id_reg_write      = rw;
        hz.id_is_mem_access  = mem;
        hz.id_is_branch      = br;
        hz.id_is_mdu         = mdu;
    endtask

    task automatic nop();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Drive at the falling edge, settle 1 time unit, then checks run.
    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nop();
        end
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        nop();
        reset = 1'b1;
        #1;
        chk("reset_stall", int'(hz.stall), 0);
        chk("reset_ex_rs", int'(hz.ex_fwd_rs_sel), 0);
        chk("reset_ex_rt", int'(hz.ex_fwd_rt_sel), 0);
        chk("reset_mdu_busy", int'(hz.mdu_busy), 0);
        chk("reset_stall_count", int'(hz.stall_count), 0);
        @(negedge clk);
        reset = 1'b0;

        // lw t0,0(sp) ; addu t1,t0,t2
        next();
        issue(1, 5'd29, 5'd0, 5'd8, 1, 1, 0, 0);
        #1 chk("lw_no_stall", int'(hz.stall), 0);
        next();
        issue(1, 5'd8, 5'd10, 5'd9, 1, 0, 0, 0);
        #1 chk("loaduse_stall", int'(hz.stall), 1);
        next();
        chk("loaduse_release", int'(hz.stall), 0);
        chk("loaduse_count", int'(hz.stall_count), 1);
        next();
        nop();
        chk("loaduse_ex_rs", int'(hz.ex_fwd_rs_sel), 2);
        chk("loaduse_ex_rt", int'(hz.ex_fwd_rt_sel), 0);
        flush();

        // addu t0 ; subu t1,t2,t0 back-to-back
        issue(1, 5'd10, 5'd11, 5'd8, 1, 0, 0, 0);
        next();
        issue(1, 5'd10, 5'd8, 5'd9, 1, 0, 0, 0);
        #1 chk("b2b_no_stall", int'(hz.stall), 0);
        next();
        nop();
        chk("b2b_ex_rt", int'(hz.ex_fwd_rt_sel), 1);
        chk("b2b_ex_rs", int'(hz.ex_fwd_rs_sel), 0);
        flush();

        // addu t0 ; nop ; subu t1,t2,t0
        issue(1, 5'd10, 5'd11, 5'd8, 1, 0, 0, 0);
        next();
        nop();
        next();
        issue(1, 5'd10, 5'd8, 5'd9, 1, 0, 0, 0);
        #1 chk("gap_no_stall", int'(hz.stall), 0);
        next();
        nop();
        chk("gap_ex_rt", int'(hz.ex_fwd_rt_sel), 2);
        flush();

        // addu t0 ; beq t0,t1
        issue(1, 5'd10, 5'd11, 5'd8, 1, 0, 0, 0);
        next();
        issue(1, 5'd8, 5'd9, 5'd0, 0, 0, 1, 0);
        #1 chk("alu_br_stall", int'(hz.stall), 1);
        next();
        chk("alu_br_release", int'(hz.stall), 0);
        chk("alu_br_rs_sel", int'(hz.id_br_fwd_rs_sel), 1);
        chk("alu_br_rt_sel", int'(hz.id_br_fwd_rt_sel), 0);
        flush();

        // lw t0 ; beq t0,t1 -> two stall cycles
        issue(1, 5'd29, 5'd0, 5'd8, 1, 1, 0, 0);
        next();
        issue(1, 5'd8, 5'd9, 5'd0, 0, 0, 1, 0);
        #1 chk("ld_br_stall1", int'(hz.stall), 1);
        next();
        chk("ld_br_stall2", int'(hz.stall), 1);
        next();
        chk("ld_br_release", int'(hz.stall), 0);
        chk("ld_br_rs_sel", int'(hz.id_br_fwd_rs_sel), 2);
        chk("ld_br_count", int'(hz.stall_count), 4);
        flush();

        // mult t0,t1 ; mflo t3 -> eight stall cycles
        issue(1, 5'd8, 5'd9, 5'd0, 0, 0, 0, 1);
        next();
        issue(1, 5'd0, 5'd0, 5'd11, 1, 0, 0, 1);
        #1 chk("mdu_busy_set", int'(hz.mdu_busy), 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!hz.stall) break;
            cnt++;
            next();
        end
        chk("mdu_stall_cycles", cnt, 8);
        chk("mdu_busy_clear", int'(hz.mdu_busy), 0);
        chk("mdu_count", int'(hz.stall_count), 12);
        flush();

        // addu $0 ; addu t1,$0,$0 ; beq $0,$0
        issue(1, 5'd8, 5'd9, 5'd0, 1, 0, 0, 0);
        next();
        issue(1, 5'd0, 5'd0, 5'd9, 1, 0, 0, 0);
        #1 chk("zero_no_stall", int'(hz.stall), 0);
        next();
        issue(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        #1 chk("zero_ex_rs", int'(hz.ex_fwd_rs_sel), 0);
        chk("zero_ex_rt", int'(hz.ex_fwd_rt_sel), 0);
        chk("zero_br_stall", int'(hz.stall), 0);
        chk("zero_br_rs", int'(hz.id_br_fwd_rs_sel), 0);
        chk("zero_br_rt", int'(hz.id_br_fwd_rt_sel), 0);
        flush();

        // Reset during a load-use stall
        issue(1, 5'd29, 5'd0, 5'd8, 1, 1, 0, 0);
        next();
        issue(1, 5'd8, 5'd10, 5'd9, 1, 0, 0, 0);
        #1 chk("rst_lu_stall_pre", int'(hz.stall), 1);
        #1 reset = 1'b1;
        #1 chk("rst_lu_stall", int'(hz.stall), 0);
        chk("rst_lu_count", int'(hz.stall_count), 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_lu_after", int'(hz.stall), 0);
        flush();

        // Reset during an MDU busy window, with a live EX select
        issue(1, 5'd10, 5'd11, 5'd8, 1, 0, 0, 0);
        next();
        issue(1, 5'd8, 5'd9, 5'd0, 0, 0, 0, 1);
        next();
        issue(1, 5'd0, 5'd0, 5'd11, 1, 0, 0, 1);
        #1 chk("rst_mdu_stall_pre", int'(hz.stall), 1);
        chk("rst_mdu_ex_rs_pre", int'(hz.ex_fwd_rs_sel), 1);
        #1 reset = 1'b1;
        #1 chk("rst_mdu_busy", int'(hz.mdu_busy), 0);
        chk("rst_mdu_stall", int'(hz.stall), 0);
        chk("rst_mdu_ex_rs", int'(hz.ex_fwd_rs_sel), 0);
        chk("rst_mdu_count", int'(hz.stall_count), 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_mdu_after", int'(hz.stall), 0);
        next();
        nop();
        chk("rst_mdu_busy_after", int'(hz.mdu_busy), 0);
        chk("rst_mdu_count_after", int'(hz.stall_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Consumer end of the partial-decode interface: takes the per-instruction decode fields produced in ID and tracks in-flight register writers through EX, MEM and WB.
- Produces the ID stall, registered EX forwarding selects, and ID branch-operand forwarding selects.
- Tracks a multi-cycle MDU (mult/div/HI-LO) busy window.
- Sits beside the ID/EX pipeline register in the 5-stage MIPS core.

Parameters:
MDU_CYCLES, 8, cycles HI/LO stay busy after an MDU write-op issues into EX (≥1)
STALL_CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs_addr  in  5  source register 1 (0 = none)
id_rt_addr  in  5  source register 2 (0 = none)
id_write_reg_addr  in  5  destination register
id_reg_write  in  1  instruction writes GPR
id_is_mem_access  in  1  load/store
id_is_branch  in  1  branch/jump resolved in ID
id_is_mdu  in  1  MDU class instruction
stall  out  1  hold PC and IF/ID, inject bubble into EX (combinational)
ex_fwd_rs_sel  out  2  EX operand rs source: 0 regfile, 1 EX/MEM result, 2 MEM/WB result (registered)
ex_fwd_rt_sel  out  2  same for rt (registered)
id_br_fwd_rs_sel  out  2  branch operand rs in ID: 0 regfile, 1 EX/MEM, 2 MEM/WB (combinational)
id_br_fwd_rt_sel  out  2  same for rt
mdu_busy  out  1  MDU busy counter nonzero
stall_count  out  STALL_CNT_W  cycles with stall=1, wraps

Behaviour:
- Derived classes:
  - load = is_mem_access & reg_write.
  - A writer is tracked only if reg_write=1 and dst≠0.
  - mdu_wr = is_mdu & ~reg_write (mult/div/mthi/mtlo).
  - mdu_rd = is_mdu & reg_write (mfhi/mflo).
- Slot state: EX, MEM, WB slots, each holding {valid, dst, is_load}. Every clock:
  - WB<=MEM, MEM<=EX.
  - EX<=ID fields if advance = id_valid & ~stall; otherwise EX<=bubble (valid=0).
- Match(slot, r) = slot.valid & r≠0 & r==slot.dst.
- stall=1 iff id_valid and any of:
  - (a) Load-use: Match(EX, rs|rt) & EX.is_load.
  - (b) Branch needs a value not yet produced: id_is_branch & Match(EX, rs|rt), any EX writer.
  - (c) Branch after load: id_is_branch & Match(MEM, rs|rt) & MEM.is_load.
  - (d) MDU busy: id_is_mdu & mdu_busy.
- Branch ID selects, per operand:
  - 1 if Match(MEM) & ~MEM.is_load.
  - Else 2 if Match(WB).
  - Else 0.
  - Value is don't-care when stall=1.
- EX selects: registered on advance, computed from current slots (which become MEM/WB next cycle):
  - 1 if Match(EX).
  - Else 2 if Match(MEM).
  - Else 0.
  - Newer producer wins.
  - On bubble the selects clear to 0.
  - A load in EX never yields 1 for an advancing consumer, because (a) stalls first.
- MDU counter (width clog2(MDU_CYCLES+1)):
  - Loads MDU_CYCLES when an mdu_wr instruction advances.
  - Otherwise decrements if nonzero.
  - mdu_busy = counter≠0.
  - mdu_rd or mdu_wr in ID while busy stalls.
- stall_count increments each cycle stall=1 and wraps at 2^STALL_CNT_W.
- Reset (async): all slots invalid, MDU counter 0, stall_count 0, ex_fwd selects 0.
  - Therefore stall=0 and id_br selects=0 immediately.
  - Reset mid-stall or mid-MDU aborts everything; the first post-reset instruction sees no hazards.
- Simultaneous conditions: stall takes priority over advance; counter reload and decrement never coincide (reload wins).
- id_valid=0: stall=0, EX receives a bubble.

Test Plan:
- lw $t0 then addu $t1,$t0,$t2:
  - stall=1 for exactly 1 cycle, stall_count=1.
  - When addu advances, ex_fwd_rs_sel=2 next cycle.
- addu $t0 then subu $t1,$t2,$t0 back-to-back: no stall, ex_fwd_rt_sel=1. Insert one NOP between them: ex_fwd_rt_sel=2.
- addu $t0 then beq $t0,$t1:
  - stall 1 cycle, then id_br_fwd_rs_sel=1.
  - lw $t0 then beq: 2 stall cycles, then id_br_fwd_rs_sel=2.
- With MDU_CYCLES=8: mult issues, then mflo in ID next cycle.
  - mdu_busy=1, stall held until the counter reaches 0.
  - mflo advances on the cycle mdu_busy first reads 0.
- Writer with dst=$0 (addu $0,...) followed by a reader of $0: no stall, all selects 0.
- Assert reset during a load-use stall and during an MDU busy window:
  - All outputs return to 0 asynchronously.
  - stall_count=0.
  - The next instruction advances with no stall.
